ether_payload_feeder: RTL and testbench

ETHER_PAYLOAD_FEEDER -- requirements
Module: ether_payload_feeder

---
 rtl/ether_payload_feeder_if.sv | 23 ++
 rtl/ether_payload_feeder.sv | 134 +++++++++++++
 tb/tb_ether_payload_feeder.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ether_payload_feeder_if.sv
// Handshake bundle between the payload source, the feeder and the downstream transmitter.
// master = byte source / transmitter side, slave = feeder.
interface ether_payload_feeder_if;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_last;
    logic       byte_ready;
    logic       data_request;
    logic       preamble_signal;
    logic       axiov;
    logic [1:0] axiod;
    logic       overflow;

    modport master (
        output byte_valid, byte_data, byte_last, data_request,
        input  byte_ready, preamble_signal, axiov, axiod, overflow
    );

    modport slave (
        input  byte_valid, byte_data, byte_last, data_request,
        output byte_ready, preamble_signal, axiov, axiod, overflow
    );
endinterface

// File: rtl/ether_payload_feeder.sv
// Buffers one frame of payload bytes, announces it with a preamble pulse, then streams it
// LSB-dibit-first after a fixed delay from data_request, zero-padding up to MIN_BYTES.
module ether_payload_feeder #(
    parameter int DEPTH       = 64,
    parameter int MIN_BYTES   = 46,
    parameter int START_DELAY = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    ether_payload_feeder_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = CW + 2;

    typedef enum logic [2:0] {IDLE, ARMED, WAIT_REQ, DELAY, STREAM} state_t;

    state_t        state, state_n;
    logic [7:0]    buffer [DEPTH];
    logic [CW-1:0] byte_count, byte_count_n;
    logic [DW-1:0] dib_idx, dib_idx_n;
    logic [3:0]    dly, dly_n;
    logic          byte_ready_n, axiov_n, preamble_n, overflow_n;
    logic [1:0]    axiod_n;

    logic          accept;
    logic [CW-1:0] frame_len;
    logic [DW-1:0] last_dib;
    logic [DW-1:0] nxt_dib;
    logic [CW-1:0] nxt_byte;
    logic [7:0]    nxt_data;
    logic [1:0]    nxt_dibit;

    assign accept    = bus.byte_valid && bus.byte_ready && (state == IDLE);
    assign frame_len = (byte_count > CW'(MIN_BYTES)) ? byte_count : CW'(MIN_BYTES);
    assign last_dib  = {frame_len, 2'b00} - DW'(1);

    // Dibit presented on the next edge: index 0 when leaving DELAY, else the successor.
    assign nxt_dib  = (state == STREAM) ? dib_idx + DW'(1) : '0;
    assign nxt_byte = nxt_dib[DW-1:2];
    assign nxt_data = (nxt_byte < byte_count) ? buffer[nxt_byte[AW-1:0]] : 8'h00;

    always_comb begin
        nxt_dibit = nxt_data[1:0];
        case (nxt_dib[1:0])
            2'd0: nxt_dibit = nxt_data[1:0];
            2'd1: nxt_dibit = nxt_data[3:2];
            2'd2: nxt_dibit = nxt_data[5:4];
            2'd3: nxt_dibit = nxt_data[7:6];
            default: nxt_dibit = nxt_data[1:0];
        endcase
    end

    always_comb begin
        state_n      = state;
        byte_count_n = byte_count;
        dib_idx_n    = dib_idx;
        dly_n        = dly;
        axiov_n      = 1'b0;
        axiod_n      = 2'b00;
        preamble_n   = 1'b0;
        overflow_n   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    byte_count_n = byte_count + CW'(1);
                    if (bus.byte_last || byte_count_n == CW'(DEPTH)) begin
                        state_n    = ARMED;
                        preamble_n = 1'b1;
                        overflow_n = !bus.byte_last;
                    end
                end
            end
            ARMED: state_n = WAIT_REQ;
            WAIT_REQ: begin
                if (bus.data_request) begin
                    state_n = DELAY;
                    dly_n   = '0;
                end
            end
            DELAY: begin
                dly_n = dly + 4'd1;
                // The edge that sampled data_request counts as edge 0.
                if (dly == 4'(START_DELAY - 1)) begin
                    state_n   = STREAM;
                    dib_idx_n = '0;
                    axiov_n   = 1'b1;
                    axiod_n   = nxt_dibit;
                end
            end
            STREAM: begin
                if (dib_idx == last_dib) begin
                    state_n      = IDLE;
                    byte_count_n = '0;
                end else begin
                    dib_idx_n = nxt_dib;
                    axiov_n   = 1'b1;
                    axiod_n   = nxt_dibit;
                end
            end
            default: state_n = IDLE;
        endcase
        byte_ready_n = (state_n == IDLE) && (byte_count_n < CW'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state               <= IDLE;
            byte_count          <= '0;
            dib_idx             <= '0;
            dly                 <= '0;
            bus.byte_ready      <= 1'b0;
            bus.axiov           <= 1'b0;
            bus.axiod           <= 2'b00;
            bus.preamble_signal <= 1'b0;
            bus.overflow        <= 1'b0;
        end else begin
            state               <= state_n;
            byte_count          <= byte_count_n;
            dib_idx             <= dib_idx_n;
            dly                 <= dly_n;
            bus.byte_ready      <= byte_ready_n;
            bus.axiov           <= axiov_n;
            bus.axiod           <= axiod_n;
            bus.preamble_signal <= preamble_n;
            bus.overflow        <= overflow_n;
        end
    end

    // Frame storage needs no reset; only indices below byte_count are ever read.
    always_ff @(posedge clk) begin
        if (accept) buffer[byte_count[AW-1:0]] <= bus.byte_data;
    end
endmodule

// File: tb/tb_ether_payload_feeder.sv
// Bench for ether_payload_feeder: table of frames checked against a byte-to-dibit model,
// plus hand sequences for ignored requests, blocked bytes and mid-stream reset.
module tb_ether_payload_feeder;
    localparam int DEPTH       = 64;
    localparam int MIN_BYTES   = 46;
    localparam int START_DELAY = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ether_payload_feeder_if bus ();

    ether_payload_feeder #(
        .DEPTH(DEPTH), .MIN_BYTES(MIN_BYTES), .START_DELAY(START_DELAY)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int pre_cnt = 0, ovf_cnt = 0, ovf_pre = 0, gap_viol = 0;
    always @(negedge clk) begin
        if (bus.preamble_signal) pre_cnt++;
        if (bus.overflow) ovf_cnt++;
        if (bus.overflow && bus.preamble_signal) ovf_pre++;
        if (!bus.axiov && bus.axiod != 2'b00) gap_viol++;
    end

    logic [7:0] frame_q[$];
    logic [1:0] exp_q[$];
    logic [1:0] got_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    // Reference: payload of max(n, MIN_BYTES) bytes, zero-padded, each byte sent bits 1:0 first.
    task automatic build_exp();
        int n, len;
        logic [7:0] b;
        exp_q.delete();
        n   = frame_q.size();
        len = (n > MIN_BYTES) ? n : MIN_BYTES;
        for (int i = 0; i < 4 * len; i++) begin
            b = (i / 4 < n) ? frame_q[i / 4] : 8'h00;
            exp_q.push_back(b[2 * (i % 4) +: 2]);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        int t = 0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = d;
        bus.byte_last  = last;
        while (!bus.byte_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) timeout("byte_ready_wait");
        @(negedge clk);
        bus.byte_valid = 1'b0;
        bus.byte_last  = 1'b0;
    endtask

    task automatic load_frame(input bit use_last);
        for (int i = 0; i < frame_q.size(); i++)
            send_byte(frame_q[i], use_last && (i == frame_q.size() - 1));
    endtask

    task automatic request_and_wait(input string name);
        int k = 0;
        bus.data_request = 1'b1;
        @(negedge clk);
        bus.data_request = 1'b0;
        while (!bus.axiov && k < START_DELAY + 20) begin
            @(negedge clk);
            k++;
        end
        check({name, "_latency"}, k, START_DELAY);
    endtask

    task automatic stream_check(input string name, input int exp_len);
        int t = 0;
        int bad = -1;
        request_and_wait(name);
        got_q.delete();
        while (bus.axiov && t < 2000) begin
            got_q.push_back(bus.axiod);
            @(negedge clk);
            t++;
        end
        if (t >= 2000) timeout({name, "_stream_end"});
        check({name, "_dibits"}, got_q.size(), exp_len);
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (bad < 0 && got_q[i] !== exp_q[i]) begin
                bad = i;
                $display("  dibit %0d of %s: got %0d, model %0d", i, name, got_q[i], exp_q[i]);
            end
        check({name, "_first_bad_dibit"}, bad, -1);
        check({name, "_axiod_idle"}, bus.axiod, 0);
        check({name, "_ready_after"}, bus.byte_ready, 1);
    endtask

    typedef struct {
        int n;
        int pat;          // 0: fixed 1B FF 00 80, 1: incrementing, 2: random
        bit use_last;
        int exp_ovf;
        int exp_dibits;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int base_pre, base_ovf, base_op, seen;
        logic [1:0] head [8];
        logic [1:0] tail [4];
        head = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd3, 2'd3, 2'd3};
        tail = '{2'd3, 2'd2, 2'd3, 2'd0};

        tbl[0] = '{4,  0, 1'b1, 0, 184};
        tbl[1] = '{60, 1, 1'b1, 0, 240};
        tbl[2] = '{64, 2, 1'b0, 1, 256};
        tbl[3] = '{46, 2, 1'b1, 0, 184};
        tbl[4] = '{1,  2, 1'b1, 0, 184};
        tbl[5] = '{64, 2, 1'b1, 0, 256};
        tbl[6] = '{45, 2, 1'b1, 0, 184};
        tbl[7] = '{47, 1, 1'b1, 0, 188};

        bus.byte_valid   = 1'b0;
        bus.byte_data    = 8'h00;
        bus.byte_last    = 1'b0;
        bus.data_request = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_byte_ready", bus.byte_ready, 0);
        check("rst_axiov", bus.axiov, 0);
        check("rst_axiod", bus.axiod, 0);
        check("rst_preamble", bus.preamble_signal, 0);
        check("rst_overflow", bus.overflow, 0);
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_release", bus.byte_ready, 1);

        // data_request while idle must not start anything
        base_pre = pre_cnt;
        bus.data_request = 1'b1;
        @(negedge clk);
        bus.data_request = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.axiov) seen++;
        end
        check("idle_req_axiov", seen, 0);
        check("idle_req_preamble", pre_cnt - base_pre, 0);

        foreach (tbl[v]) begin
            string nm;
            nm = $sformatf("vec%0d", v);
            frame_q.delete();
            for (int i = 0; i < tbl[v].n; i++) begin
                if (tbl[v].pat == 1) frame_q.push_back(8'(i));
                else frame_q.push_back(8'($urandom));
            end
            if (tbl[v].pat == 0) frame_q = '{8'h1B, 8'hFF, 8'h00, 8'h80};
            base_pre = pre_cnt;
            base_ovf = ovf_cnt;
            base_op  = ovf_pre;
            load_frame(tbl[v].use_last);
            check({nm, "_ready_full"}, bus.byte_ready, 0);
            repeat (3) @(negedge clk);
            check({nm, "_preamble"}, pre_cnt - base_pre, 1);
            check({nm, "_overflow"}, ovf_cnt - base_ovf, tbl[v].exp_ovf);
            check({nm, "_ovf_with_pre"}, ovf_pre - base_op, tbl[v].exp_ovf);
            build_exp();
            stream_check(nm, tbl[v].exp_dibits);
            if (tbl[v].pat == 0)
                for (int i = 0; i < 8; i++)
                    check($sformatf("%s_head%0d", nm, i), (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF, 32'(head[i]));
            if (tbl[v].pat == 1 && tbl[v].n == 60)
                for (int i = 0; i < 4; i++)
                    check($sformatf("%s_tail%0d", nm, 236 + i), (236 + i < got_q.size()) ? 32'(got_q[236 + i]) : 32'hFFFF, 32'(tail[i]));
        end

        // Bytes offered while waiting for the request are refused and not stored
        frame_q.delete();
        for (int i = 0; i < 50; i++) frame_q.push_back(8'($urandom));
        load_frame(1'b1);
        repeat (2) @(negedge clk);
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'hAA;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("wait_req_ready%0d", i), bus.byte_ready, 0);
            @(negedge clk);
        end
        bus.byte_valid = 1'b0;
        build_exp();
        stream_check("blocked_bytes", 200);

        // Reset in the middle of a stream
        frame_q.delete();
        for (int i = 0; i < 20; i++) frame_q.push_back(8'($urandom));
        load_frame(1'b1);
        repeat (3) @(negedge clk);
        build_exp();
        request_and_wait("abort");
        got_q.delete();
        for (int i = 0; i < 50; i++) begin
            got_q.push_back(bus.axiod);
            @(negedge clk);
        end
        seen = 0;
        for (int i = 0; i < 50; i++) if (got_q[i] !== exp_q[i]) seen++;
        check("abort_prefix_errors", seen, 0);
        rst = 1'b0;
        @(negedge clk);
        check("abort_axiov", bus.axiov, 0);
        check("abort_ready_in_rst", bus.byte_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        check("abort_ready_release", bus.byte_ready, 1);
        seen = 0;
        repeat (10) begin
            if (bus.axiov) seen++;
            @(negedge clk);
        end
        check("abort_no_dibits", seen, 0);

        frame_q.delete();
        for (int i = 0; i < 30; i++) frame_q.push_back(8'($urandom));
        base_pre = pre_cnt;
        load_frame(1'b1);
        repeat (3) @(negedge clk);
        check("post_abort_preamble", pre_cnt - base_pre, 1);
        build_exp();
        stream_check("post_abort", 184);

        check("axiod_zero_when_invalid", gap_viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
